// File: rtl/qsn_syndrome_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qsn_syndrome_acc                                                         |
// | Per-row XOR syndrome accumulator with per-frame unsatisfied-check report |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qsn_syndrome_acc #(
  parameter int LIFT     = 4,
  parameter int NUM_ROWS = 8,
  parameter int ROW_W    = 3,
  parameter int UNSAT_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LIFT-1:0]    in_data,
  input  logic               in_last,
  output logic               syn_valid,
  input  logic               syn_ready,
  output logic [LIFT-1:0]    syn_data,
  output logic [ROW_W-1:0]   syn_row,
  output logic               done,
  output logic               pass,
  output logic [UNSAT_W-1:0] unsat_count
);

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    EMIT   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(NUM_ROWS - 1);

  state_t               r_state;
  logic [LIFT-1:0]      r_acc;
  logic [ROW_W-1:0]     r_row;
  logic [UNSAT_W-1:0]   r_cnt;

  logic [LIFT-1:0]      w_acc_next;
  logic [UNSAT_W-1:0]   w_pop;
  logic [UNSAT_W:0]     w_sum;
  logic [UNSAT_W-1:0]   w_cnt_next;

  function automatic logic [UNSAT_W-1:0] popcnt(input logic [LIFT-1:0] v);
    logic [UNSAT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LIFT; i++) begin
      n = n + UNSAT_W'(v[i]);
    end
    return n;
  endfunction

  assign w_acc_next = r_acc ^ in_data;
  assign w_pop      = popcnt(w_acc_next);
  assign w_sum      = {1'b0, r_cnt} + {1'b0, w_pop};
  // Saturate instead of wrapping so an overflowing frame can never look clean.
  assign w_cnt_next = w_sum[UNSAT_W] ? {UNSAT_W{1'b1}} : w_sum[UNSAT_W-1:0];

  // Gated by rst_n so upstream sees no acceptance while reset is held.
  assign in_ready = rst_n & (r_state == ACC);
  assign done     = (r_state == REPORT) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      syn_valid   <= 1'b0;
      syn_data    <= '0;
      syn_row     <= '0;
      pass        <= 1'b0;
      unsat_count <= '0;
    end else if (clr) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      syn_valid   <= 1'b0;
      syn_data    <= '0;
      syn_row     <= '0;
      pass        <= 1'b0;
      unsat_count <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (in_valid) begin
            if (in_last) begin
              syn_data  <= w_acc_next;
              syn_row   <= r_row;
              syn_valid <= 1'b1;
              r_cnt     <= w_cnt_next;
              r_acc     <= '0;
              r_state   <= EMIT;
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        EMIT: begin
          if (syn_ready) begin
            syn_valid <= 1'b0;
            if (r_row == c_last_row) begin
              r_state <= REPORT;
            end else begin
              r_row   <= r_row + ROW_W'(1);
              r_state <= ACC;
            end
          end
        end
        REPORT: begin
          unsat_count <= r_cnt;
          pass        <= (r_cnt == '0);
          r_row       <= '0;
          r_cnt       <= '0;
          r_state     <= ACC;
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qsn_syndrome_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qsn_syndrome_acc                                                      |
// | Directed self-checking bench for qsn_syndrome_acc                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_qsn_syndrome_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       syn_valid;
  logic       syn_ready;
  logic [3:0] syn_data;
  logic [2:0] syn_row;
  logic       done;
  logic       pass;
  logic [5:0] unsat_count;

  int checks   = 0;
  int failures = 0;

  qsn_syndrome_acc #(
    .LIFT(4), .NUM_ROWS(8), .ROW_W(3), .UNSAT_W(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn_data   (syn_data),
    .syn_row    (syn_row),
    .done       (done),
    .pass       (pass),
    .unsat_count(unsat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // One row with syn_ready already high: optional first block a, last block b.
  task automatic row(input logic [3:0] a, input logic [3:0] b, input logic two,
                     input logic [3:0] exp, input logic [2:0] r);
    if (two) send(a, 1'b0);
    send(b, 1'b1);
    chk("syn_valid", {31'd0, syn_valid}, 32'd1);
    chk("syn_data", {28'd0, syn_data}, {28'd0, exp});
    chk("syn_row", {29'd0, syn_row}, {29'd0, r});
    chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
    tick();
    chk("syn_valid_drop", {31'd0, syn_valid}, 32'd0);
  endtask

  task automatic frame_end(input logic exp_pass, input logic [5:0] exp_unsat);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("in_ready_report", {31'd0, in_ready}, 32'd0);
    tick();
    chk("done_low", {31'd0, done}, 32'd0);
    chk("pass", {31'd0, pass}, {31'd0, exp_pass});
    chk("unsat_count", {26'd0, unsat_count}, {26'd0, exp_unsat});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0;
    syn_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_syn_valid", {31'd0, syn_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-row: partial accumulation must be lost.
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("after_rst_syn_valid", {31'd0, syn_valid}, 32'd0);
    chk("after_rst_pass", {31'd0, pass}, 32'd0);
    chk("after_rst_unsat", {26'd0, unsat_count}, 32'd0);

    // Frame A: row 0 = 0001^0011^0100 = 0110, remaining rows zero -> unsat 2.
    send(4'b0001, 1'b0);
    send(4'b0011, 1'b0);
    row(4'b0000, 4'b0100, 1'b0, 4'b0110, 3'd0);
    for (int i = 1; i < 8; i++) row(4'b0000, 4'b0000, 1'b0, 4'b0000, 3'(i));
    frame_end(1'b0, 6'd2);

    // Frame B: every row 1010^1010 = 0000 -> pass.
    for (int i = 0; i < 8; i++) row(4'b1010, 4'b1010, 1'b1, 4'b0000, 3'(i));
    frame_end(1'b1, 6'd0);

    // Frame C: row 2 = 0110, row 5 = 1111 -> unsat 6.
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      row(4'b0000, 4'b0110, 1'b0, 4'b0110, 3'(i));
      else if (i == 5) row(4'b0011, 4'b1100, 1'b1, 4'b1111, 3'(i));
      else             row(4'b1010, 4'b1010, 1'b1, 4'b0000, 3'(i));
    end
    frame_end(1'b0, 6'd6);

    // Frame D: backpressure on row 0 with upstream pushing changing data.
    syn_ready = 1'b0;
    send(4'b0111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k + 9);
      in_last  = k[0];
      tick();
      chk("bp_syn_valid", {31'd0, syn_valid}, 32'd1);
      chk("bp_syn_data", {28'd0, syn_data}, 32'h7);
      chk("bp_syn_row", {29'd0, syn_row}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    syn_ready = 1'b1;
    tick();
    chk("bp_release", {31'd0, syn_valid}, 32'd0);
    row(4'b0000, 4'b0101, 1'b0, 4'b0101, 3'd1);
    row(4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd2);
    row(4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd3);

    // Abort frame D part-way through row 4.
    send(4'b0011, 1'b0);
    send(4'b0100, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_syn_valid", {31'd0, syn_valid}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_unsat", {26'd0, unsat_count}, 32'd0);
    tick();
    chk("clr_no_done", {31'd0, done}, 32'd0);

    // Frame E: clean all-zero frame starting from row 0.
    for (int i = 0; i < 8; i++) row(4'b0000, 4'b0000, 1'b0, 4'b0000, 3'(i));
    frame_end(1'b1, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
